// File: rtl/riscv_defines.sv
// Shared trap types, sequencer state encoding and machine-mode CSR addresses.
package riscv_defines;

  localparam int TRAP_XLEN = 32;

  typedef enum logic {
    TRAP_ENTER  = 1'b0,
    TRAP_RETURN = 1'b1
  } trap_mode_t;

  typedef enum logic [4:0] {
    CAUSE_INSN_MISALIGNED = 5'd0,
    CAUSE_INSN_FAULT      = 5'd1,
    CAUSE_ILLEGAL_INSN    = 5'd2,
    CAUSE_BREAKPOINT      = 5'd3,
    CAUSE_ECALL_M         = 5'd11
  } trap_cause_t;

  typedef struct packed {
    logic                 valid;
    trap_mode_t           mode;
    logic [TRAP_XLEN-1:0] cause;
    logic [TRAP_XLEN-1:0] pc;
    logic [TRAP_XLEN-1:0] tval;
  } trap_req_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MTVAL   = 3'd3,
    W_MSTATUS = 3'd4,
    REDIRECT  = 3'd5
  } trap_seq_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

endpackage

// File: rtl/trap_target.sv
// Redirect target: mtvec direct/vectored entry for traps, aligned mepc for returns.
module trap_target #(
  parameter int XLEN = 32
) (
  input  logic            i_is_return,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic [XLEN-1:0] i_cause,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_offset;
  logic            w_vectored;

  assign w_base     = i_mtvec & ~XLEN'(3);
  // Shifting drops the interrupt bit, giving 4*cause[XLEN-2:0] mod 2^XLEN.
  assign w_offset   = i_cause << 2;
  assign w_vectored = (i_mtvec[1:0] == 2'b01) && i_cause[XLEN-1];

  always_comb begin
    if (i_is_return) o_target = i_mepc & ~XLEN'(3);
    else if (w_vectored) o_target = w_base + w_offset;
    else o_target = w_base;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences machine-mode trap entry/return: CSR writes one per cycle, then a PC redirect.
module trap_sequencer
  import riscv_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  trap_req_t       trap_req_m,
  output logic            trap_ready,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mstatus,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            flush_all,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  trap_seq_state_t r_state;
  trap_mode_t      r_mode;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tval;

  logic            w_idle;
  logic            w_accept;
  logic [XLEN-1:0] w_mstatus_new;
  logic [XLEN-1:0] w_target;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = !rst && w_idle && trap_req_m.valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    // NOTE: only the control/capture registers need reset; all outputs are
    // gated by the state, so the captured data is cleared just for hygiene.
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= TRAP_ENTER;
      r_cause <= '0;
      r_pc    <= '0;
      r_tval  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (trap_req_m.valid) begin
            r_mode  <= trap_req_m.mode;
            r_cause <= trap_req_m.cause;
            r_pc    <= trap_req_m.pc;
            r_tval  <= trap_req_m.tval;
            r_state <= (trap_req_m.mode == TRAP_RETURN) ? W_MSTATUS : W_MEPC;
          end
        end
        W_MEPC:    r_state <= W_MCAUSE;
        W_MCAUSE:  r_state <= W_MTVAL;
        W_MTVAL:   r_state <= W_MSTATUS;
        W_MSTATUS: r_state <= REDIRECT;
        default:   r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_mstatus_new        = mstatus;
    w_mstatus_new[12:11] = 2'b11;
    if (r_mode == TRAP_RETURN) begin
      w_mstatus_new[3] = mstatus[7];
      w_mstatus_new[7] = 1'b1;
    end else begin
      w_mstatus_new[7] = mstatus[3];
      w_mstatus_new[3] = 1'b0;
    end
  end

  // Target is evaluated from the live CSR inputs in the REDIRECT cycle.
  trap_target #(.XLEN(XLEN)) u_trap_target (
    .i_is_return (r_mode == TRAP_RETURN),
    .i_mtvec     (mtvec),
    .i_mepc      (mepc),
    .i_cause     (r_cause),
    .o_target    (w_target)
  );

  assign trap_ready = rst || w_idle;
  assign flush_all  = !rst && (w_accept || !w_idle);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      case (r_state)
        W_MEPC: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = r_pc;
        end
        W_MCAUSE: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MCAUSE;
          csr_wdata = r_cause;
        end
        W_MTVAL: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MTVAL;
          csr_wdata = r_tval;
        end
        W_MSTATUS: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = w_mstatus_new;
        end
        REDIRECT: begin
          redirect_valid = 1'b1;
          redirect_pc    = w_target;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: per-cycle output vectors against hand-computed values.
module tb_trap_sequencer;
  import riscv_defines::*;

  typedef struct packed {
    logic        ready;
    logic        flush;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  trap_req_t   trap_req_m;
  logic        trap_ready;
  logic [31:0] mtvec, mepc, mstatus;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int tests = 0;
  int fails = 0;

  trap_sequencer #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_req_m     (trap_req_m),
    .trap_ready     (trap_ready),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .mstatus        (mstatus),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .flush_all      (flush_all),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return '{trap_ready, flush_all, csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc};
  endfunction

  function automatic obs_t idle_o();
    return '{1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0};
  endfunction

  function automatic obs_t accept_o();
    return '{1'b1, 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0};
  endfunction

  function automatic obs_t wr(input logic [11:0] a, input logic [31:0] d);
    return '{1'b0, 1'b1, 1'b1, a, d, 1'b0, 32'h0};
  endfunction

  function automatic obs_t redir(input logic [31:0] pc);
    return '{1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, pc};
  endfunction

  task automatic set_req(input logic v, input trap_mode_t m, input logic [31:0] cause,
                         input logic [31:0] pc, input logic [31:0] tval);
    trap_req_m.valid = v;
    trap_req_m.mode  = m;
    trap_req_m.cause = cause;
    trap_req_m.pc    = pc;
    trap_req_m.tval  = tval;
  endtask

  task automatic test_reset();
    obs_t exp [3];
    obs_t got;
    exp = '{idle_o(), idle_o(), idle_o()};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rst = (c < 2);
      set_req(c < 2, TRAP_ENTER, 32'd2, 32'h80, 32'h0);
      #1;
      got = sample();
      tests++;
      if (got !== exp[c]) begin
        fails++;
        $display("FAIL reset cyc%0d: got %h expected %h", c, got, exp[c]);
      end
    end
  endtask

  task automatic test_enter_illegal();
    obs_t exp [7];
    obs_t got;
    exp = '{accept_o(), wr(12'h341, 32'h80), wr(12'h342, 32'h2),
            wr(12'h343, 32'hFFFF_FFFF), wr(12'h300, 32'h1880), redir(32'h100), idle_o()};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mtvec   = 32'h0000_0100;
        mstatus = 32'h8;
        set_req(1'b1, TRAP_ENTER, 32'd2, 32'h80, 32'hFFFF_FFFF);
      end else trap_req_m.valid = 1'b0;
      #1;
      got = sample();
      tests++;
      if (got !== exp[c]) begin
        fails++;
        $display("FAIL enter_illegal cyc%0d: got %h expected %h", c, got, exp[c]);
      end
    end
  endtask

  // Vectored interrupt enter, a stray request in W_MCAUSE, then a return
  // presented in the first cycle after REDIRECT.
  task automatic test_back_to_back();
    obs_t exp [10];
    obs_t got;
    exp = '{accept_o(), wr(12'h341, 32'h44), wr(12'h342, 32'h8000_0007),
            wr(12'h343, 32'h0), wr(12'h300, 32'h1800), redir(32'h21C),
            accept_o(), wr(12'h300, 32'h1880), redir(32'h200), idle_o()};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          mtvec   = 32'h0000_0201;
          mstatus = 32'h0;
          set_req(1'b1, TRAP_ENTER, 32'h8000_0007, 32'h44, 32'h0);
        end
        2: set_req(1'b1, TRAP_RETURN, 32'h5, 32'hDEAD_BEE0, 32'h1234);
        6: begin
          mepc    = 32'h0000_0200;
          mstatus = 32'h1800;
          set_req(1'b1, TRAP_RETURN, 32'h0, 32'h0, 32'h0);
        end
        default: trap_req_m.valid = 1'b0;
      endcase
      #1;
      got = sample();
      tests++;
      if (got !== exp[c]) begin
        fails++;
        $display("FAIL back_to_back cyc%0d: got %h expected %h", c, got, exp[c]);
      end
    end
  endtask

  task automatic test_return();
    obs_t exp [4];
    obs_t got;
    exp = '{accept_o(), wr(12'h300, 32'h1888), redir(32'h120), idle_o()};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mepc    = 32'h0000_0123;
        mstatus = 32'h1880;
        set_req(1'b1, TRAP_RETURN, 32'h0, 32'h0, 32'h0);
      end else trap_req_m.valid = 1'b0;
      #1;
      got = sample();
      tests++;
      if (got !== exp[c]) begin
        fails++;
        $display("FAIL return cyc%0d: got %h expected %h", c, got, exp[c]);
      end
    end
  endtask

  // Vectored mtvec with a synchronous cause goes to the base; mtvec changes
  // in the REDIRECT cycle must be reflected in the target.
  task automatic test_vector_sync_late_mtvec();
    obs_t exp [7];
    obs_t got;
    exp = '{accept_o(), wr(12'h341, 32'h10), wr(12'h342, 32'h2),
            wr(12'h343, 32'h5), wr(12'h300, 32'h1880), redir(32'h400), idle_o()};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mtvec   = 32'h0000_0301;
        mstatus = 32'h1808;
        set_req(1'b1, TRAP_ENTER, 32'd2, 32'h10, 32'h5);
      end else begin
        trap_req_m.valid = 1'b0;
        if (c == 5) mtvec = 32'h0000_0401;
      end
      #1;
      got = sample();
      tests++;
      if (got !== exp[c]) begin
        fails++;
        $display("FAIL vector_sync cyc%0d: got %h expected %h", c, got, exp[c]);
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    obs_t exp [9];
    obs_t got;
    exp = '{accept_o(), wr(12'h341, 32'h80), wr(12'h342, 32'h2),
            idle_o(), idle_o(), idle_o(), idle_o(), idle_o(), idle_o()};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mtvec   = 32'h0000_0100;
        mstatus = 32'h8;
        set_req(1'b1, TRAP_ENTER, 32'd2, 32'h80, 32'hFFFF_FFFF);
      end else trap_req_m.valid = 1'b0;
      rst = (c == 3);
      #1;
      got = sample();
      tests++;
      if (got !== exp[c]) begin
        fails++;
        $display("FAIL reset_mid cyc%0d: got %h expected %h", c, got, exp[c]);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    trap_req_m = '0;
    mtvec      = '0;
    mepc       = '0;
    mstatus    = '0;
    test_reset();
    test_enter_illegal();
    test_back_to_back();
    test_return();
    test_vector_sync_late_mtvec();
    test_reset_mid_sequence();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data width of PC, CSR and cause values.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port trap_req_m, input, trap_req_t: the committing trap request (fields valid, mode, cause, pc, tval).
REQ-005 SHALL have port trap_ready, output, 1 bit: high only in IDLE, when a request can be accepted.
REQ-006 SHALL have port mtvec, input, XLEN bits: the current mtvec CSR value.
REQ-007 SHALL have port mepc, input, XLEN bits: the current mepc CSR value.
REQ-008 SHALL have port mstatus, input, XLEN bits: the current mstatus CSR value.
REQ-009 SHALL have port csr_we, output, 1 bit: the CSR file write enable.
REQ-010 SHALL have port csr_waddr, output, 12 bits: the CSR write address.
REQ-011 SHALL have port csr_wdata, output, XLEN bits: the CSR write data.
REQ-012 SHALL have port flush_all, output, 1 bit: flushes every pipeline stage.
REQ-013 SHALL have port redirect_valid, output, 1 bit: a one-cycle PC redirect strobe.
REQ-014 SHALL have port redirect_pc, output, XLEN bits: the redirect target, valid while redirect_valid is high.

Function
REQ-015 SHALL implement FSM states IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS and REDIRECT.
REQ-016 SHALL, in IDLE with trap_req_m.valid high, capture the request into internal registers.
REQ-017 SHALL move IDLE to W_MEPC when the captured mode is TRAP_ENTER, and IDLE to W_MSTATUS when it is TRAP_RETURN.
REQ-018 SHALL sequence an enter as W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIRECT, IDLE, one cycle per state.
REQ-019 SHALL sequence a return as W_MSTATUS, REDIRECT, IDLE.
REQ-020 SHALL perform one CSR write per W_* state, with csr_we high for exactly that cycle:
- W_MEPC: address 0x341, data = captured pc.
- W_MCAUSE: address 0x342, data = captured cause.
- W_MTVAL: address 0x343, data = captured tval.
- W_MSTATUS: address 0x300.
REQ-021 SHALL, on enter, write mstatus as the input mstatus with MPIE[7] set to MIE[3], MIE[3] cleared, and MPP[12:11] set to 2'b11.
REQ-022 SHALL, on return, write mstatus as the input mstatus with MIE[3] set to MPIE[7], MPIE[7] set to 1, and MPP[12:11] set to 2'b11.
REQ-023 SHALL compute the enter target from mtvec[1:0]:
- 01 with cause[31]=1: {mtvec[31:2],2'b00} + 4*cause[30:0], modulo 2^XLEN.
- Any other value: {mtvec[31:2],2'b00}.
REQ-024 SHALL use mepc with bits [1:0] forced to 0 as the return target.
REQ-025 SHALL sample the target in REDIRECT, so the redirect uses the CSR inputs as of that cycle.
REQ-026 SHALL assert redirect_valid only in REDIRECT, one cycle, which is accept + 5 cycles for an enter and accept + 2 cycles for a return.
REQ-027 SHALL drive flush_all combinationally high:
- in the accept cycle;
- in every non-IDLE state up to and including REDIRECT.
REQ-028 SHALL ignore trap_req_m.valid in any non-IDLE state: no capture and no state change.
REQ-029 SHALL accept a valid request presented in the cycle immediately after REDIRECT; no dead cycle is permitted.
REQ-030 SHALL drive csr_waddr and csr_wdata to 0 and redirect_pc to 0 whenever the corresponding strobe is low.

Reset
REQ-031 SHALL, with rst high at a clock edge, go to IDLE and clear the captured request, from any state including mid-sequence.
REQ-032 SHALL, during and after reset, hold csr_we, flush_all and redirect_valid at 0 and trap_ready at 1, with all data outputs 0.
REQ-033 SHALL NOT emit a partial redirect or CSR write after rst deasserts.

Structure
REQ-034 SHALL place the following in riscv_defines, with trap_req_t and the trap mode/cause enums reused from there:
- the state enum trap_seq_state_t;
- the CSR address constants CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE and CSR_MTVAL.
REQ-035 SHALL place the target computation of REQ-023/REQ-024 in one combinational sub-module, trap_target.

Verification
REQ-036 SHALL cover illegal-instruction enter with mtvec=0x0000_0100, pc=0x80, tval=0xFFFF_FFFF, mstatus=0x8:
- writes 0x341/0x80, 0x342/2, 0x343/0xFFFF_FFFF and 0x300/0x1880 in consecutive cycles;
- redirect_pc=0x100 at accept+5.
REQ-037 SHALL cover vectored interrupt enter with mtvec=0x0000_0201 and cause=0x8000_0007 -> redirect_pc=0x21C.
REQ-038 SHALL cover return with mepc=0x0000_0123 and mstatus=0x1880 -> single write 0x300/0x1888; redirect_pc=0x120 at accept+2.
REQ-039 SHALL cover a second valid request in W_MCAUSE -> ignored, sequence unchanged; a request in the cycle after REDIRECT -> accepted.
REQ-040 SHALL cover rst asserted in W_MTVAL -> next cycle IDLE, no further csr_we, no redirect_valid, trap_ready=1.
